// File: rtl/frog_pkg.sv
// Shared types and defaults for the frog game tracker: the game state encoding,
// the default board and game constants, and a counter-width helper.
package frog_pkg;

    typedef enum logic [1:0] {PLAY, HIT_HOLD, WIN_HOLD, OVER} game_state_t;

    localparam int DEF_ROWS     = 8;
    localparam int DEF_COLS     = 8;
    localparam int DEF_LIVES    = 3;
    localparam int DEF_SCORE_W  = 4;
    localparam int DEF_HOLD_CYC = 16;

    // Width needed to count 0..n-1, kept at least 1 bit so a 1-cycle hold still builds.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frog_game_tracker_rise_detect.sv
// One-bit rising-edge detector. It registers the input and flags the cycle in
// which the input is high while the registered copy is still low.
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic prev_d, prev_q;

    always_comb prev_d = din;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_q <= 1'b0;
        else          prev_q <= prev_d;
    end

    assign rise = din & ~prev_q;

endmodule

// File: rtl/frog_game_tracker.sv
// Registered frog/car board checker. Detects collisions and crossings and tracks
// lives, score, the post-event hold period and game-over.
module frog_game_tracker
    import frog_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    parameter int LIVES    = DEF_LIVES,
    parameter int SCORE_W  = DEF_SCORE_W,
    parameter int HOLD_CYC = DEF_HOLD_CYC
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [ROWS-1:0][COLS-1:0]     frog,
    input  logic [ROWS-1:0][COLS-1:0]     cars,
    input  logic                          up,
    input  logic                          restart,
    output logic                          crashed,
    output logic                          survived,
    output logic                          respawn,
    output logic                          game_over,
    output logic [$clog2(LIVES+1)-1:0]    lives_left,
    output logic [SCORE_W-1:0]            score
);

    localparam int LW = $clog2(LIVES + 1);
    localparam int CW = cnt_w(HOLD_CYC);

    logic up_rise, hit, escape;

    rise_detect u_up_rise (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (up),
        .rise    (up_rise)
    );

    // A goal-row crossing only counts on a fresh key press with no collision.
    assign hit    = |(frog & cars);
    assign escape = up_rise & (|frog[ROWS-1]) & ~hit;

    game_state_t        state_d, state_q;
    logic [CW-1:0]      cnt_d, cnt_q;
    logic [LW-1:0]      lives_d, lives_q;
    logic [SCORE_W-1:0] score_d, score_q;
    logic               crashed_d, crashed_q;
    logic               survived_d, survived_q;
    logic               respawn_d, respawn_q;
    logic               game_over_d, game_over_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lives_d     = lives_q;
        score_d     = score_q;
        crashed_d   = 1'b0;
        survived_d  = 1'b0;
        respawn_d   = 1'b0;
        game_over_d = game_over_q;

        unique case (state_q)
            PLAY: begin
                if (hit) begin
                    crashed_d = 1'b1;
                    lives_d   = lives_q - 1'b1;
                    // Checking for the last life before decrementing keeps lives from wrapping.
                    if (lives_q == LW'(1)) begin
                        state_d     = OVER;
                        game_over_d = 1'b1;
                    end else begin
                        state_d = HIT_HOLD;
                        cnt_d   = '0;
                    end
                end else if (escape) begin
                    survived_d = 1'b1;
                    score_d    = (score_q == '1) ? score_q : score_q + 1'b1;
                    state_d    = WIN_HOLD;
                    cnt_d      = '0;
                end
            end
            HIT_HOLD, WIN_HOLD: begin
                if (cnt_q == CW'(HOLD_CYC - 1)) begin
                    respawn_d = 1'b1;
                    state_d   = PLAY;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OVER: begin
                if (restart) begin
                    lives_d     = LW'(LIVES);
                    score_d     = '0;
                    respawn_d   = 1'b1;
                    game_over_d = 1'b0;
                    state_d     = PLAY;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= PLAY;
            cnt_q       <= '0;
            lives_q     <= LW'(LIVES);
            score_q     <= '0;
            crashed_q   <= 1'b0;
            survived_q  <= 1'b0;
            respawn_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            crashed_q   <= crashed_d;
            survived_q  <= survived_d;
            respawn_q   <= respawn_d;
            game_over_q <= game_over_d;
        end
    end

    assign crashed    = crashed_q;
    assign survived   = survived_q;
    assign respawn    = respawn_q;
    assign game_over  = game_over_q;
    assign lives_left = lives_q;
    assign score      = score_q;

endmodule
